match_ram_encoder: RTL and testbench

- Match-vector store plus encoder for a block-RAM CAM slice.
- True dual-port RAM holding 2**ADDR_WIDTH words of DATA_WIDTH bits. Port A is the compare/lookup port; port B is the read-modify-write maintenance port.
- Port A's registered read word feeds a priority encoder that reports the winning match index.
- Sits between CAM control logic (drives port B) and the match output (uses port A and the encoder).

---
 rtl/match_ram_encoder_pkg.sv | 25 ++
 rtl/match_ram_encoder_lsb_priority_encoder.sv | 62 ++++++
 rtl/match_ram_encoder.sv | 89 ++++++++
 tb/tb_match_ram_encoder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/match_ram_encoder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : match_ram_encoder_pkg
//  Description : Shared constants and helpers for the match-vector store and
//                its priority encoder.
//                  c_prio_high / c_prio_low : LSB_PRIORITY selector strings.
//                                             "HIGH" means the lowest set bit
//                                             wins. "LOW" means the highest
//                                             set bit wins.
//                  clog2_min1()             : index width, never below 1.
//  Revision    : 1.0  initial release
// ============================================================================
package match_ram_encoder_pkg;

    localparam string c_prio_high = "HIGH";
    localparam string c_prio_low  = "LOW";

    // Width of an index into a vector of 'value' bits. The minimum is 1 so
    // that degenerate widths still produce a legal port.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage : match_ram_encoder_pkg
`default_nettype wire

// File: rtl/match_ram_encoder_lsb_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_priority_encoder
//  Description : Balanced-tree priority encoder. The input is zero-padded up to
//                the next power of two. Each tree node forwards the valid flag
//                and absolute index of its winning child, so the logic depth
//                is about log2(WIDTH) multiplexer stages.
//  Ports       : data      in  WIDTH  vector to encode
//                valid     out 1      at least one bit of data is set
//                encoded   out IW     index of the winning bit (0 if none set)
//                unencoded out WIDTH  one-hot of the winning bit (0 if none)
//  Revision    : 1.0  initial release
// ============================================================================
module lsb_priority_encoder
    import match_ram_encoder_pkg::*;
#(
    parameter int    WIDTH        = 32,
    parameter string LSB_PRIORITY = "HIGH",
    localparam int   IW           = clog2_min1(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    output logic             valid,
    output logic [IW-1:0]    encoded,
    output logic [WIDTH-1:0] unencoded
);

    localparam int c_pad          = 1 << IW;
    localparam bit c_lowest_wins  = (LSB_PRIORITY == c_prio_high);

    // Heap-ordered tree. Node 1 is the root, and the children of node n are
    // 2n (the lower bit positions) and 2n+1. Leaves occupy c_pad..2*c_pad-1.
    logic          w_node_valid [1:2*c_pad-1];
    logic [IW-1:0] w_node_index [1:2*c_pad-1];

    for (genvar n = c_pad; n < 2*c_pad; n++) begin : g_leaf
        if (n - c_pad < WIDTH) begin : g_real
            assign w_node_valid[n] = data[n-c_pad];
        end else begin : g_pad
            // Padding bits are tied off so they can never win.
            assign w_node_valid[n] = 1'b0;
        end
        assign w_node_index[n] = IW'(n - c_pad);
    end

    for (genvar n = 1; n < c_pad; n++) begin : g_node
        logic w_take_hi;
        if (c_lowest_wins) begin : g_lowest_first
            assign w_take_hi = !w_node_valid[2*n];
        end else begin : g_highest_first
            assign w_take_hi = w_node_valid[2*n+1];
        end
        assign w_node_valid[n] = w_node_valid[2*n] | w_node_valid[2*n+1];
        assign w_node_index[n] = w_take_hi ? w_node_index[2*n+1] : w_node_index[2*n];
    end

    // The root index is meaningless when nothing is set, so force it to zero.
    assign valid     = w_node_valid[1];
    assign encoded   = valid ? w_node_index[1] : '0;
    assign unencoded = valid ? (WIDTH'(1) << encoded) : '0;

endmodule : lsb_priority_encoder
`default_nettype wire

// File: rtl/match_ram_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : match_ram_encoder
//  Description : True dual-port read-first RAM holding CAM match vectors.
//                The registered read word of port A feeds a priority encoder.
//                Port A is the lookup port. Port B is the maintenance
//                (read-modify-write) port.
//  Ports       : clk, rst_n                   clock, async active-low reset
//                a_we/a_addr/a_din/a_dout     port A (lookup)
//                b_we/b_addr/b_din/b_dout     port B (maintenance)
//                enc_valid/enc_index/enc_onehot  encoder of a_dout
//  Revision    : 1.0  initial release
// ============================================================================
module match_ram_encoder
    import match_ram_encoder_pkg::*;
#(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 9,
    parameter string LSB_PRIORITY = "HIGH",
    localparam int   IDX_WIDTH    = clog2_min1(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_din,
    output logic [DATA_WIDTH-1:0] a_dout,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_din,
    output logic [DATA_WIDTH-1:0] b_dout,
    output logic                  enc_valid,
    output logic [IDX_WIDTH-1:0]  enc_index,
    output logic [DATA_WIDTH-1:0] enc_onehot
);

    localparam int c_depth = 1 << ADDR_WIDTH;

    // There is no reset and no init file, so the array powers up as all zeros
    // (the default block-RAM configuration state). A mid-run reset keeps the
    // stored contents.
    logic [DATA_WIDTH-1:0] r_mem [0:c_depth-1];
    logic [DATA_WIDTH-1:0] r_a_dout;
    logic [DATA_WIDTH-1:0] r_b_dout;

    // Both write ports share one process. Port B is written last, so its
    // data is stored when both ports write the same address on one edge.
    always_ff @(posedge clk) begin
        if (a_we) begin
            r_mem[a_addr] <= a_din;
        end
        if (b_we) begin
            r_mem[b_addr] <= b_din;
        end
    end

    // Non-blocking reads sample the pre-edge contents. This gives read-first
    // behaviour on the writing port and old data on the other port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_dout <= '0;
        end else begin
            r_a_dout <= r_mem[a_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_dout <= '0;
        end else begin
            r_b_dout <= r_mem[b_addr];
        end
    end

    assign a_dout = r_a_dout;
    assign b_dout = r_b_dout;

    lsb_priority_encoder #(
        .WIDTH        (DATA_WIDTH),
        .LSB_PRIORITY (LSB_PRIORITY)
    ) u_encoder (
        .data      (r_a_dout),
        .valid     (enc_valid),
        .encoded   (enc_index),
        .unencoded (enc_onehot)
    );

endmodule : match_ram_encoder
`default_nettype wire

// File: tb/tb_match_ram_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_match_ram_encoder
//  Description : Self-checking bench for match_ram_encoder. Two instances
//                share every input. One uses LSB_PRIORITY "HIGH" and the
//                other "LOW". A reference memory produces the expected read
//                data, which goes into a queue when stimulus is applied and
//                is popped when the registered output appears.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_match_ram_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_we = 1'b0;
    logic [8:0]  a_addr = '0;
    logic [31:0] a_din = '0;
    logic        b_we = 1'b0;
    logic [8:0]  b_addr = '0;
    logic [31:0] b_din = '0;

    logic [31:0] a_dout, b_dout, enc_onehot;
    logic        enc_valid;
    logic [4:0]  enc_index;
    logic [31:0] lo_a_dout, lo_b_dout, lo_onehot;
    logic        lo_valid;
    logic [4:0]  lo_index;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;
    exp_t        sb[$];
    logic [31:0] ref_mem [0:511];

    always #5 clk = ~clk;

    match_ram_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .LSB_PRIORITY("HIGH")) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout),
        .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout),
        .enc_valid(enc_valid), .enc_index(enc_index), .enc_onehot(enc_onehot)
    );

    match_ram_encoder #(.DATA_WIDTH(32), .ADDR_WIDTH(9), .LSB_PRIORITY("LOW")) u_dut_low (
        .clk(clk), .rst_n(rst_n),
        .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(lo_a_dout),
        .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(lo_b_dout),
        .enc_valid(lo_valid), .enc_index(lo_index), .enc_onehot(lo_onehot)
    );

    function automatic int ref_lowest(input logic [31:0] v);
        for (int i = 0; i < 32; i++) if (v[i]) return i;
        return 0;
    endfunction

    function automatic int ref_highest(input logic [31:0] v);
        for (int i = 31; i >= 0; i--) if (v[i]) return i;
        return 0;
    endfunction

    // Drives one cycle and records the expected read data. The reference
    // memory is read-first: it reads, then applies A's write, then B's write.
    // On return the outputs of this cycle are stable.
    task automatic step(input bit awe, input logic [8:0] aa, input logic [31:0] ad,
                        input bit bwe, input logic [8:0] ba, input logic [31:0] bd);
        exp_t e;
        @(negedge clk);
        a_we = awe; a_addr = aa; a_din = ad;
        b_we = bwe; b_addr = ba; b_din = bd;
        e.a = ref_mem[aa];
        e.b = ref_mem[ba];
        sb.push_back(e);
        if (awe) ref_mem[aa] = ad;
        if (bwe) ref_mem[ba] = bd;
        @(posedge clk);
        #1;
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    task automatic test_reset_powerup();
        #3;
        n_checks++;
        if (a_dout !== 32'h0 || b_dout !== 32'h0 || enc_valid !== 1'b0 ||
            enc_index !== 5'd0 || enc_onehot !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_powerup actual a=%h b=%h v=%b i=%0d oh=%h required all zero",
                     a_dout, b_dout, enc_valid, enc_index, enc_onehot);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fresh_memory();
        exp_t e;
        logic [8:0] addrs [3] = '{9'd0, 9'd100, 9'd511};
        foreach (addrs[i]) begin
            step(1'b0, addrs[i], 32'h0, 1'b0, 9'(addrs[i] - 9'd1), 32'h0);
            e = sb.pop_front();
            n_checks++;
            if (a_dout !== 32'h0 || b_dout !== 32'h0 || a_dout !== e.a || enc_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL fresh_mem addr=%0d actual a=%h b=%h v=%b required 0/0/0",
                         addrs[i], a_dout, b_dout, enc_valid);
            end
        end
    endtask

    task automatic test_port_b_write_read();
        exp_t e;
        step(1'b0, 9'd0, 32'h0, 1'b1, 9'd5, 32'h0000_0120);
        e = sb.pop_front();
        step(1'b0, 9'd5, 32'h0, 1'b0, 9'd0, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (a_dout !== e.a || a_dout !== 32'h120) begin
            n_fail++;
            $display("FAIL portb_rd a_dout actual=%h required=%h", a_dout, 32'h120);
        end
        n_checks++;
        if (enc_valid !== 1'b1 || enc_index !== 5'd5 || enc_onehot !== 32'h20) begin
            n_fail++;
            $display("FAIL portb_enc_high actual v=%b i=%0d oh=%h required 1/5/00000020",
                     enc_valid, enc_index, enc_onehot);
        end
        n_checks++;
        if (lo_valid !== 1'b1 || lo_index !== 5'd8 || lo_onehot !== 32'h100) begin
            n_fail++;
            $display("FAIL portb_enc_low actual v=%b i=%0d oh=%h required 1/8/00000100",
                     lo_valid, lo_index, lo_onehot);
        end
    endtask

    task automatic test_read_first();
        exp_t e;
        step(1'b0, 9'd0, 32'h0, 1'b1, 9'd3, 32'hAAAA_0000);
        e = sb.pop_front();
        // Port B writes addr 3 while both ports read it.
        step(1'b0, 9'd3, 32'h0, 1'b1, 9'd3, 32'h0000_0001);
        e = sb.pop_front();
        n_checks++;
        if (b_dout !== e.b || b_dout !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL rf_b_old actual=%h required=%h", b_dout, 32'hAAAA_0000);
        end
        n_checks++;
        if (a_dout !== e.a || a_dout !== 32'hAAAA_0000) begin
            n_fail++;
            $display("FAIL rf_a_cross_old actual=%h required=%h", a_dout, 32'hAAAA_0000);
        end
        step(1'b0, 9'd3, 32'h0, 1'b0, 9'd3, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (a_dout !== e.a || b_dout !== e.b || b_dout !== 32'h1) begin
            n_fail++;
            $display("FAIL rf_new actual a=%h b=%h required=%h", a_dout, b_dout, 32'h1);
        end
    endtask

    task automatic test_collision();
        exp_t e;
        step(1'b1, 9'd7, 32'h11, 1'b1, 9'd7, 32'h22);
        e = sb.pop_front();
        step(1'b0, 9'd7, 32'h0, 1'b0, 9'd7, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (a_dout !== 32'h22 || b_dout !== 32'h22 || a_dout !== e.a) begin
            n_fail++;
            $display("FAIL collision actual a=%h b=%h required=%h", a_dout, b_dout, 32'h22);
        end
    endtask

    task automatic test_encoder_sweep();
        exp_t        e;
        logic [31:0] pats [$];
        int          eh, el;
        logic [31:0] ohh, ohl;
        pats.push_back(32'h0);
        for (int k = 0; k < 32; k++) pats.push_back(32'h1 << k);
        pats.push_back(32'h8000_0001);
        for (int k = 0; k < 6; k++) pats.push_back($urandom());
        foreach (pats[i]) begin
            step(1'b0, 9'd0, 32'h0, 1'b1, 9'd40, pats[i]);
            e = sb.pop_front();
            step(1'b0, 9'd40, 32'h0, 1'b0, 9'd0, 32'h0);
            e = sb.pop_front();
            eh  = ref_lowest(e.a);
            el  = ref_highest(e.a);
            ohh = (e.a != 0) ? (32'h1 << eh) : 32'h0;
            ohl = (e.a != 0) ? (32'h1 << el) : 32'h0;
            n_checks++;
            if (a_dout !== e.a || enc_valid !== (e.a != 0) ||
                enc_index !== 5'(eh) || enc_onehot !== ohh) begin
                n_fail++;
                $display("FAIL enc_high pat=%h actual v=%b i=%0d oh=%h required v=%b i=%0d oh=%h",
                         e.a, enc_valid, enc_index, enc_onehot, (e.a != 0), eh, ohh);
            end
            n_checks++;
            if (lo_valid !== (e.a != 0) || lo_index !== 5'(el) || lo_onehot !== ohl) begin
                n_fail++;
                $display("FAIL enc_low pat=%h actual v=%b i=%0d oh=%h required v=%b i=%0d oh=%h",
                         e.a, lo_valid, lo_index, lo_onehot, (e.a != 0), el, ohl);
            end
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        step(1'b0, 9'd5, 32'h0, 1'b0, 9'd3, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (a_dout !== e.a || b_dout !== e.b || a_dout === 32'h0) begin
            n_fail++;
            $display("FAIL pre_reset actual a=%h b=%h required a=%h b=%h", a_dout, b_dout, e.a, e.b);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (a_dout !== 32'h0 || b_dout !== 32'h0 || enc_valid !== 1'b0 ||
            enc_index !== 5'd0 || enc_onehot !== 32'h0 || lo_index !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_async actual a=%h b=%h v=%b i=%0d oh=%h required all zero",
                     a_dout, b_dout, enc_valid, enc_index, enc_onehot);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Memory contents survive the reset.
        step(1'b0, 9'd5, 32'h0, 1'b0, 9'd7, 32'h0);
        e = sb.pop_front();
        n_checks++;
        if (a_dout !== 32'h120 || b_dout !== 32'h22 || a_dout !== e.a) begin
            n_fail++;
            $display("FAIL reset_keeps_mem actual a=%h b=%h required a=%h b=%h",
                     a_dout, b_dout, 32'h120, 32'h22);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom(),
                 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom());
            e = sb.pop_front();
            n_checks++;
            if (a_dout !== e.a || b_dout !== e.b || lo_a_dout !== e.a) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d actual a=%h b=%h required a=%h b=%h",
                         i, a_dout, b_dout, e.a, e.b);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = 32'h0;
        test_reset_powerup();
        test_fresh_memory();
        test_port_b_write_read();
        test_read_first();
        test_collision();
        test_encoder_sweep();
        test_reset_midrun();
        test_back_to_back();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_match_ram_encoder
`default_nettype wire
